// File: rtl/lcd_seq_pkg.sv
// Shared types, init ROM and command classification for the LCD sequencer.
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_IDLE  = 3'd2,
        ST_SETUP = 3'd3,
        ST_PULSE = 3'd4,
        ST_HOLD  = 3'd5,
        ST_WAIT  = 3'd6
    } lcd_state_t;

    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned IDX_W    = 3;

    // HD44780 8-bit init: function set x3, display on, clear, entry mode.
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear display (0x01) and return home (0x02/0x03) need the long execute wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module lcd_seq_timer #(
    parameter int unsigned       CNT_W       = 20,
    parameter logic [CNT_W-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero_c
);

    logic [CNT_W-1:0] count;

    // Load has priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/de2_115_lcd_sequencer.sv
// Avalon-MM master shaping command/data bytes into HD44780 write cycles, with power-up init.
module de2_115_lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned E_CYCLES       = 12,
    parameter int unsigned SHORT_WAIT     = 2000,
    parameter int unsigned LONG_WAIT      = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       init_done,
    output logic       busy,
    output logic [1:0] lcd_address,
    output logic       lcd_write,
    output logic       lcd_read,
    output logic [7:0] lcd_writedata
);

    localparam int unsigned MAX_CNT = (POWERUP_CYCLES > LONG_WAIT) ? POWERUP_CYCLES : LONG_WAIT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    // Timer holds N-1 so that a phase lasts exactly N cycles including the zero cycle.
    localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_WAIT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT - 1);

    lcd_state_t       state;
    logic [IDX_W-1:0] idx;
    logic             timer_load_c;
    logic [CNT_W-1:0] timer_value_c;
    logic             timer_zero_c;

    lcd_seq_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (PWRUP_LOAD)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load_c),
        .load_value (timer_value_c),
        .zero_c     (timer_zero_c)
    );

    // Timer reload on entry to each timed phase; the latched byte picks the execute wait.
    always_comb begin
        timer_load_c  = 1'b0;
        timer_value_c = '0;
        unique case (state)
            ST_INIT: begin
                timer_load_c  = 1'b1;
                timer_value_c = SETUP_LOAD;
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    timer_load_c  = 1'b1;
                    timer_value_c = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (timer_zero_c) begin
                    timer_load_c  = 1'b1;
                    timer_value_c = E_LOAD;
                end
            end
            ST_HOLD: begin
                timer_load_c  = 1'b1;
                timer_value_c = is_long_cmd(lcd_address[1], lcd_writedata) ? LONG_LOAD : SHORT_LOAD;
            end
            default: ;
        endcase
    end

    // Sequencer state and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_PWRUP;
            idx           <= '0;
            cmd_ready     <= 1'b0;
            init_done     <= 1'b0;
            busy          <= 1'b1;
            lcd_address   <= 2'b00;
            lcd_write     <= 1'b0;
            lcd_read      <= 1'b0;
            lcd_writedata <= 8'h00;
        end else begin
            lcd_read <= 1'b0;
            unique case (state)
                ST_PWRUP: begin
                    if (timer_zero_c) begin
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    lcd_address   <= 2'b00;
                    lcd_writedata <= INIT_ROM[idx];
                    state         <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lcd_address   <= {cmd_rs, 1'b0};
                        lcd_writedata <= cmd_data;
                        cmd_ready     <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_zero_c) begin
                        lcd_write <= 1'b1;
                        state     <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (timer_zero_c) begin
                        lcd_write <= 1'b0;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (timer_zero_c) begin
                        if (init_done || (idx == IDX_W'(INIT_LEN - 1))) begin
                            init_done <= 1'b1;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_INIT;
                        end
                    end
                end
                default: begin
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule
